// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative divider with result cache.
// Helpers work on a wide vector so any DATA_W up to MaxW can reuse them.
package div_pkg;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} div_state_e;

  localparam int unsigned MaxW = 64;

  typedef logic [MaxW-1:0] wide_t;

  // Most negative two's-complement value for a w-bit operand.
  function automatic wide_t min_val(input int unsigned w);
    return wide_t'(1) << (w - 1);
  endfunction

  function automatic wide_t cond_neg(input wide_t v, input logic neg);
    return neg ? (~v + wide_t'(1)) : v;
  endfunction

endpackage

// File: rtl/div_cache_unit_if.sv
// Request/response handshake bundle between the ALU and the divider.
interface div_cache_unit_if #(
  parameter int unsigned DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] rem;
  logic              out_hit;
  logic              flush;
  logic              cache_inv;

  modport master (
    output in_valid, in_sign, op1, op2, out_ready, flush, cache_inv,
    input  in_ready, out_valid, quo, rem, out_hit
  );

  modport slave (
    input  in_valid, in_sign, op1, op2, out_ready, flush, cache_inv,
    output in_ready, out_valid, quo, rem, out_hit
  );
endinterface

// File: rtl/div_result_cache.sv
// Small fully-associative cache of completed divisions, filled round-robin.
module div_result_cache #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned CACHE_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] i_lk_op1,
  input  logic [DATA_W-1:0] i_lk_op2,
  input  logic              i_lk_sign,
  output logic              o_hit,
  output logic [DATA_W-1:0] o_quo,
  output logic [DATA_W-1:0] o_rem,
  input  logic              i_we,
  input  logic [DATA_W-1:0] i_wr_op1,
  input  logic [DATA_W-1:0] i_wr_op2,
  input  logic              i_wr_sign,
  input  logic [DATA_W-1:0] i_wr_quo,
  input  logic [DATA_W-1:0] i_wr_rem,
  input  logic              i_inv
);

  localparam int unsigned PtrW = (CACHE_DEPTH > 1) ? $clog2(CACHE_DEPTH) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(CACHE_DEPTH - 1);

  logic [CACHE_DEPTH-1:0] r_valid;
  logic [PtrW-1:0]        r_ptr;
  logic [DATA_W-1:0]      r_op1  [CACHE_DEPTH];
  logic [DATA_W-1:0]      r_op2  [CACHE_DEPTH];
  logic                   r_sign [CACHE_DEPTH];
  logic [DATA_W-1:0]      r_quo  [CACHE_DEPTH];
  logic [DATA_W-1:0]      r_rem  [CACHE_DEPTH];

  always_ff @(posedge clk) begin
    if (!rstn || i_inv) begin
      r_valid <= '0;
      r_ptr   <= '0;
    end else if (i_we) begin
      r_valid[r_ptr] <= 1'b1;
      r_ptr          <= (r_ptr == LastPtr) ? '0 : r_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_op1[r_ptr]  <= i_wr_op1;
      r_op2[r_ptr]  <= i_wr_op2;
      r_sign[r_ptr] <= i_wr_sign;
      r_quo[r_ptr]  <= i_wr_quo;
      r_rem[r_ptr]  <= i_wr_rem;
    end
  end

  // Entries only come from misses, so at most one can match; OR-merge is safe.
  always_comb begin
    o_hit = 1'b0;
    o_quo = '0;
    o_rem = '0;
    for (int i = 0; i < CACHE_DEPTH; i++) begin
      if (r_valid[i] && r_op1[i] == i_lk_op1 && r_op2[i] == i_lk_op2 &&
          r_sign[i] == i_lk_sign) begin
        o_hit = 1'b1;
        o_quo = o_quo | r_quo[i];
        o_rem = o_rem | r_rem[i];
      end
    end
  end

endmodule

// File: rtl/div_cache_unit.sv
// Iterative radix-2 restoring divider with single-cycle short-cuts and a result cache.
module div_cache_unit
  import div_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned CACHE_DEPTH = 2
) (
  input logic             clk,
  input logic             rstn,
  div_cache_unit_if.slave bus
);

  localparam int unsigned       CntW    = $clog2(DATA_W);
  localparam logic [CntW-1:0]   CntInit = CntW'(DATA_W - 1);
  localparam logic [DATA_W-1:0] MinVal  = DATA_W'(min_val(DATA_W));

  div_state_e        r_state;
  logic [CntW-1:0]   r_cnt;
  logic [DATA_W-1:0] r_op1, r_op2;
  logic              r_sign;
  logic [DATA_W-1:0] r_dvd, r_dvs, r_part;
  logic              r_neg_q, r_neg_r;
  logic [DATA_W-1:0] r_quo, r_rem;
  logic              r_hit;

  logic              w_c_hit, w_hit, w_cache_we;
  logic [DATA_W-1:0] w_c_quo, w_c_rem;
  logic              w_div_zero, w_dvd_zero, w_ovf;
  logic              w_neg1, w_neg2;
  logic [DATA_W-1:0] w_abs1, w_abs2;
  logic [DATA_W:0]   w_shift, w_diff;
  logic              w_qbit;
  logic [DATA_W-1:0] w_part_nxt;
  logic [DATA_W-1:0] w_fix_quo, w_fix_rem;

  assign w_div_zero = (bus.op2 == '0);
  assign w_dvd_zero = (bus.op1 == '0);
  assign w_ovf      = bus.in_sign && (bus.op1 == MinVal) && (bus.op2 == '1);
  // A lookup racing an invalidate sees the post-invalidate (empty) cache.
  assign w_hit      = w_c_hit && !bus.cache_inv;

  assign w_neg1 = bus.in_sign & bus.op1[DATA_W-1];
  assign w_neg2 = bus.in_sign & bus.op2[DATA_W-1];
  assign w_abs1 = DATA_W'(cond_neg(MaxW'(bus.op1), w_neg1));
  assign w_abs2 = DATA_W'(cond_neg(MaxW'(bus.op2), w_neg2));

  // Restoring step: shift in the next dividend bit, subtract if it fits.
  assign w_shift    = {r_part, r_dvd[DATA_W-1]};
  assign w_diff     = w_shift - {1'b0, r_dvs};
  assign w_qbit     = ~w_diff[DATA_W];
  assign w_part_nxt = w_qbit ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];

  assign w_fix_quo  = DATA_W'(cond_neg(MaxW'(r_dvd), r_neg_q));
  assign w_fix_rem  = DATA_W'(cond_neg(MaxW'(r_part), r_neg_r));
  assign w_cache_we = (r_state == StFix) && !bus.flush && !bus.cache_inv;

  div_result_cache #(
    .DATA_W      (DATA_W),
    .CACHE_DEPTH (CACHE_DEPTH)
  ) u_cache (
    .clk       (clk),
    .rstn      (rstn),
    .i_lk_op1  (bus.op1),
    .i_lk_op2  (bus.op2),
    .i_lk_sign (bus.in_sign),
    .o_hit     (w_c_hit),
    .o_quo     (w_c_quo),
    .o_rem     (w_c_rem),
    .i_we      (w_cache_we),
    .i_wr_op1  (r_op1),
    .i_wr_op2  (r_op2),
    .i_wr_sign (r_sign),
    .i_wr_quo  (w_fix_quo),
    .i_wr_rem  (w_fix_rem),
    .i_inv     (bus.cache_inv)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_sign  <= 1'b0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_part  <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_hit   <= 1'b0;
    end else if (bus.flush) begin
      r_state <= StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.in_valid) begin
            r_op1  <= bus.op1;
            r_op2  <= bus.op2;
            r_sign <= bus.in_sign;
            r_hit  <= 1'b0;
            if (w_div_zero) begin
              r_quo   <= '1;
              r_rem   <= bus.op1;
              r_state <= StDone;
            end else if (w_dvd_zero) begin
              r_quo   <= '0;
              r_rem   <= '0;
              r_state <= StDone;
            end else if (w_ovf) begin
              r_quo   <= MinVal;
              r_rem   <= '0;
              r_state <= StDone;
            end else if (w_hit) begin
              r_quo   <= w_c_quo;
              r_rem   <= w_c_rem;
              r_hit   <= 1'b1;
              r_state <= StDone;
            end else begin
              r_dvd   <= w_abs1;
              r_dvs   <= w_abs2;
              r_part  <= '0;
              r_neg_q <= w_neg1 ^ w_neg2;
              r_neg_r <= w_neg1;
              r_cnt   <= CntInit;
              r_state <= StCalc;
            end
          end
        end
        StCalc: begin
          r_dvd  <= {r_dvd[DATA_W-2:0], w_qbit};
          r_part <= w_part_nxt;
          if (r_cnt == '0) begin
            r_state <= StFix;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        StFix: begin
          r_quo   <= w_fix_quo;
          r_rem   <= w_fix_rem;
          r_hit   <= 1'b0;
          r_state <= StDone;
        end
        StDone: begin
          if (bus.out_ready) begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == StIdle);
  assign bus.out_valid = (r_state == StDone);
  assign bus.quo       = r_quo;
  assign bus.rem       = r_rem;
  assign bus.out_hit   = r_hit;

endmodule

// File: tb/tb_div_cache_unit.sv
// Directed self-checking bench for div_cache_unit at DATA_W=32, CACHE_DEPTH=2.
module tb_div_cache_unit;

  localparam int unsigned W = 32;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  div_cache_unit_if #(.DATA_W(W)) bus_if ();

  div_cache_unit #(
    .DATA_W      (W),
    .CACHE_DEPTH (2)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request with out_ready high; lat counts cycles from accept to out_valid.
  task automatic do_req(input logic sign, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic inv, output int lat, output logic [W-1:0] q,
                        output logic [W-1:0] r, output logic hit);
    bus_if.in_sign   = sign;
    bus_if.op1       = a;
    bus_if.op2       = b;
    bus_if.cache_inv = inv;
    bus_if.in_valid  = 1'b1;
    step();
    bus_if.in_valid  = 1'b0;
    bus_if.cache_inv = 1'b0;
    lat = 1;
    while (!bus_if.out_valid && lat < 100) begin
      step();
      lat++;
    end
    q   = bus_if.quo;
    r   = bus_if.rem;
    hit = bus_if.out_hit;
    checks++;
    if (bus_if.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL req_timeout %h/%h: out_valid=%b required 1", a, b, bus_if.out_valid);
    end
    step();
  endtask

  task automatic test_reset();
    bus_if.in_valid  = 1'b0;
    bus_if.in_sign   = 1'b0;
    bus_if.op1       = '0;
    bus_if.op2       = '0;
    bus_if.out_ready = 1'b1;
    bus_if.flush     = 1'b0;
    bus_if.cache_inv = 1'b0;
    rstn = 1'b0;
    repeat (3) step();
    rstn = 1'b1;
    checks++;
    if (bus_if.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b required 1", bus_if.in_ready);
    end
    checks++;
    if (bus_if.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b required 0", bus_if.out_valid);
    end
    checks++;
    if ({bus_if.quo, bus_if.rem, bus_if.out_hit} !== {W'(0), W'(0), 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got quo=%h rem=%h hit=%b required 0/0/0",
               bus_if.quo, bus_if.rem, bus_if.out_hit);
    end
  endtask

  task automatic test_miss_hit();
    int lat; logic [W-1:0] q, r; logic hit;
    do_req(1'b0, 32'd100, 32'd7, 1'b0, lat, q, r, hit);
    checks++;
    if ({q, r, hit} !== {32'd14, 32'd2, 1'b0}) begin
      errors++; $display("FAIL miss_100_7: got %0d r %0d hit %b required 14 r 2 hit 0", q, r, hit);
    end
    checks++;
    if (lat !== 34) begin
      errors++; $display("FAIL miss_latency: got %0d required 34", lat);
    end
    do_req(1'b0, 32'd100, 32'd7, 1'b0, lat, q, r, hit);
    checks++;
    if ({q, r, hit} !== {32'd14, 32'd2, 1'b1}) begin
      errors++; $display("FAIL hit_100_7: got %0d r %0d hit %b required 14 r 2 hit 1", q, r, hit);
    end
    checks++;
    if (lat !== 1) begin
      errors++; $display("FAIL hit_latency: got %0d required 1", lat);
    end
  endtask

  task automatic test_signed();
    int lat; logic [W-1:0] q, r; logic hit;
    do_req(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, q, r, hit);
    checks++;
    if ({q, r, hit} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0}) begin
      errors++; $display("FAIL signed_m7_2: got %h r %h hit %b required fffffffd r ffffffff hit 0",
                         q, r, hit);
    end
    do_req(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, q, r, hit);
    checks++;
    if ({q, r, hit, lat} !== {32'h7FFF_FFFC, 32'd1, 1'b0, 34}) begin
      errors++; $display("FAIL unsigned_m7_2: got %h r %h hit %b lat %0d required 7ffffffc r 1 hit 0 lat 34",
                         q, r, hit, lat);
    end
  endtask

  task automatic test_shortcuts();
    int lat; logic [W-1:0] q, r; logic hit;
    do_req(1'b0, 32'd5, 32'd0, 1'b0, lat, q, r, hit);
    checks++;
    if ({q, r, hit, lat} !== {32'hFFFF_FFFF, 32'd5, 1'b0, 1}) begin
      errors++; $display("FAIL div_by_zero: got %h r %h hit %b lat %0d required ffffffff r 5 hit 0 lat 1",
                         q, r, hit, lat);
    end
    do_req(1'b1, 32'd0, 32'd9, 1'b0, lat, q, r, hit);
    checks++;
    if ({q, r, hit, lat} !== {32'd0, 32'd0, 1'b0, 1}) begin
      errors++; $display("FAIL zero_dividend: got %h r %h hit %b lat %0d required 0 r 0 hit 0 lat 1",
                         q, r, hit, lat);
    end
    do_req(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, q, r, hit);
    checks++;
    if ({q, r, hit, lat} !== {32'h8000_0000, 32'd0, 1'b0, 1}) begin
      errors++; $display("FAIL signed_overflow: got %h r %h hit %b lat %0d required 80000000 r 0 hit 0 lat 1",
                         q, r, hit, lat);
    end
    // Same operands unsigned are an ordinary division.
    do_req(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, q, r, hit);
    checks++;
    if ({q, r, hit, lat} !== {32'd0, 32'h8000_0000, 1'b0, 34}) begin
      errors++; $display("FAIL unsigned_min_m1: got %h r %h hit %b lat %0d required 0 r 80000000 hit 0 lat 34",
                         q, r, hit, lat);
    end
  endtask

  task automatic test_evict();
    int lat; logic [W-1:0] q, r; logic hit;
    bus_if.cache_inv = 1'b1;
    step();
    bus_if.cache_inv = 1'b0;
    do_req(1'b0, 32'd1000, 32'd3, 1'b0, lat, q, r, hit);
    do_req(1'b0, 32'd1000, 32'd7, 1'b0, lat, q, r, hit);
    checks++;
    if ({q, r, hit} !== {32'd142, 32'd6, 1'b0}) begin
      errors++; $display("FAIL evict_b_miss: got %0d r %0d hit %b required 142 r 6 hit 0", q, r, hit);
    end
    do_req(1'b0, 32'd1000, 32'd9, 1'b0, lat, q, r, hit);
    do_req(1'b0, 32'd1000, 32'd3, 1'b0, lat, q, r, hit);
    checks++;
    if ({q, r, hit, lat} !== {32'd333, 32'd1, 1'b0, 34}) begin
      errors++; $display("FAIL evict_a_remiss: got %0d r %0d hit %b lat %0d required 333 r 1 hit 0 lat 34",
                         q, r, hit, lat);
    end
    do_req(1'b0, 32'd1000, 32'd9, 1'b0, lat, q, r, hit);
    checks++;
    if ({q, r, hit, lat} !== {32'd111, 32'd1, 1'b1, 1}) begin
      errors++; $display("FAIL evict_c_hit: got %0d r %0d hit %b lat %0d required 111 r 1 hit 1 lat 1",
                         q, r, hit, lat);
    end
    bus_if.cache_inv = 1'b1;
    step();
    bus_if.cache_inv = 1'b0;
    do_req(1'b0, 32'd1000, 32'd7, 1'b0, lat, q, r, hit);
    checks++;
    if ({q, r, hit, lat} !== {32'd142, 32'd6, 1'b0, 34}) begin
      errors++; $display("FAIL inv_b_miss: got %0d r %0d hit %b lat %0d required 142 r 6 hit 0 lat 34",
                         q, r, hit, lat);
    end
  endtask

  task automatic test_flush();
    int lat; logic [W-1:0] q, r; logic hit; logic seen;
    bus_if.in_sign  = 1'b0;
    bus_if.op1      = 32'd50;
    bus_if.op2      = 32'd5;
    bus_if.in_valid = 1'b1;
    step();
    bus_if.in_valid = 1'b0;
    repeat (9) step();
    bus_if.flush = 1'b1;
    step();
    bus_if.flush = 1'b0;
    checks++;
    if ({bus_if.in_ready, bus_if.out_valid} !== 2'b10) begin
      errors++; $display("FAIL flush_calc: got in_ready=%b out_valid=%b required 1/0",
                         bus_if.in_ready, bus_if.out_valid);
    end
    seen = 1'b0;
    repeat (40) begin
      if (bus_if.out_valid) seen = 1'b1;
      step();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL flush_no_valid: got out_valid seen=%b required 0", seen);
    end
    do_req(1'b0, 32'd50, 32'd5, 1'b0, lat, q, r, hit);
    checks++;
    if ({q, r, hit, lat} !== {32'd10, 32'd0, 1'b0, 34}) begin
      errors++; $display("FAIL flush_not_cached: got %0d r %0d hit %b lat %0d required 10 r 0 hit 0 lat 34",
                         q, r, hit, lat);
    end
    // Flush with an idle request drops it, even a short-cut one.
    bus_if.op1      = 32'd5;
    bus_if.op2      = 32'd0;
    bus_if.in_valid = 1'b1;
    bus_if.flush    = 1'b1;
    step();
    bus_if.in_valid = 1'b0;
    bus_if.flush    = 1'b0;
    checks++;
    if ({bus_if.in_ready, bus_if.out_valid} !== 2'b10) begin
      errors++; $display("FAIL flush_idle_req: got in_ready=%b out_valid=%b required 1/0",
                         bus_if.in_ready, bus_if.out_valid);
    end
  endtask

  task automatic test_inv_lookup();
    int lat; logic [W-1:0] q, r; logic hit;
    do_req(1'b0, 32'd50, 32'd5, 1'b0, lat, q, r, hit);
    checks++;
    if ({hit, lat} !== {1'b1, 1}) begin
      errors++; $display("FAIL inv_pre_hit: got hit %b lat %0d required hit 1 lat 1", hit, lat);
    end
    do_req(1'b0, 32'd50, 32'd5, 1'b1, lat, q, r, hit);
    checks++;
    if ({q, r, hit, lat} !== {32'd10, 32'd0, 1'b0, 34}) begin
      errors++; $display("FAIL inv_same_cycle: got %0d r %0d hit %b lat %0d required 10 r 0 hit 0 lat 34",
                         q, r, hit, lat);
    end
  endtask

  task automatic test_hold();
    int wait_cnt;
    bus_if.out_ready = 1'b0;
    bus_if.in_sign   = 1'b0;
    bus_if.op1       = 32'd12;
    bus_if.op2       = 32'd5;
    bus_if.in_valid  = 1'b1;
    step();
    bus_if.in_valid = 1'b0;
    wait_cnt = 0;
    while (!bus_if.out_valid && wait_cnt < 100) begin
      step();
      wait_cnt++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus_if.out_valid, bus_if.in_ready, bus_if.quo, bus_if.rem} !==
          {1'b1, 1'b0, 32'd2, 32'd2}) begin
        errors++; $display("FAIL hold_cycle%0d: got v=%b rdy=%b %0d r %0d required v=1 rdy=0 2 r 2",
                           i, bus_if.out_valid, bus_if.in_ready, bus_if.quo, bus_if.rem);
      end
      step();
    end
    bus_if.out_ready = 1'b1;
    step();
    checks++;
    if ({bus_if.in_ready, bus_if.out_valid} !== 2'b10) begin
      errors++; $display("FAIL hold_release: got in_ready=%b out_valid=%b required 1/0",
                         bus_if.in_ready, bus_if.out_valid);
    end
  endtask

  task automatic test_reset_mid_calc();
    int lat; logic [W-1:0] q, r; logic hit;
    bus_if.in_sign  = 1'b0;
    bus_if.op1      = 32'd77;
    bus_if.op2      = 32'd3;
    bus_if.in_valid = 1'b1;
    step();
    bus_if.in_valid = 1'b0;
    repeat (10) step();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    checks++;
    if ({bus_if.in_ready, bus_if.out_valid, bus_if.quo, bus_if.rem, bus_if.out_hit} !==
        {1'b1, 1'b0, W'(0), W'(0), 1'b0}) begin
      errors++; $display("FAIL reset_mid_calc: got rdy=%b v=%b %h r %h hit %b required 1/0/0/0/0",
                         bus_if.in_ready, bus_if.out_valid, bus_if.quo, bus_if.rem, bus_if.out_hit);
    end
    do_req(1'b0, 32'd50, 32'd5, 1'b0, lat, q, r, hit);
    checks++;
    if ({q, r, hit, lat} !== {32'd10, 32'd0, 1'b0, 34}) begin
      errors++; $display("FAIL reset_cache_empty: got %0d r %0d hit %b lat %0d required 10 r 0 hit 0 lat 34",
                         q, r, hit, lat);
    end
  endtask

  initial begin
    test_reset();
    test_miss_hit();
    test_signed();
    test_shortcuts();
    test_evict();
    test_flush();
    test_inv_lookup();
    test_hold();
    test_reset_mid_calc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_cache_unit.md
# div_cache_unit

Parametrised iterative integer divider with a multi-entry result cache and valid/ready handshakes, successor to the fixed 32-bit two-entry divider path inside the execute-stage ALU. It accepts one signed or unsigned division per request and returns quotient and remainder. Short-cut cases return in one cycle: cache hit, zero dividend, zero divisor, signed overflow. All other requests take a fixed-latency radix-2 iteration. It sits beside the ALU in EX; the ALU stalls on `in_ready`/`out_valid` instead of an internal stall decode.

## Interface
- `DATA_W`, 32: operand/result width; ≥ 4.
- `CACHE_DEPTH`, 2: result cache entries; power of two, ≥ 1.
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: synchronous, active-low reset.
- `in_valid` in 1: request present.
- `in_ready` out 1: unit can accept; high only in IDLE.
- `in_sign` in 1: 1 = signed (div/mod), 0 = unsigned (divu/modu).
- `op1` in DATA_W: dividend.
- `op2` in DATA_W: divisor.
- `out_valid` out 1: result valid; held until accepted.
- `out_ready` in 1: consumer takes result.
- `quo` out DATA_W: quotient.
- `rem` out DATA_W: remainder.
- `out_hit` out 1: result came from cache (qualified by `out_valid`).
- `flush` in 1: abort in-flight request (pipeline cancel).
- `cache_inv` in 1: invalidate all cache entries.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: `in_ready`=1. On `in_valid`, capture the operands and `in_sign`, then classify. Priority: zero divisor > zero dividend > signed overflow > cache hit > miss.
- Short-cut to DONE:
  - Divisor 0: `quo` = all-ones, `rem` = `op1`.
  - Dividend 0: `quo` = 0, `rem` = 0.
  - Signed overflow (`op1` = MIN, `op2` = -1): `quo` = MIN, `rem` = 0.
  - Cache hit: stored `quo`/`rem`, `out_hit`=1.
- Miss: IDLE→CALC. Divide the magnitudes (two's-complement abs when signed). The counter is loaded with DATA_W-1. One restoring step per cycle produces one quotient bit, MSB first.
- CALC→FIX when the counter reaches 0 (exactly DATA_W CALC cycles).
- FIX: apply signs. Quotient is negated if the operand signs differ; remainder takes the dividend's sign. Write {op1, op2, sign, quo, rem} into the cache entry at the round-robin pointer, then increment the pointer (wraps at CACHE_DEPTH). Go to DONE.
- Only FIX writes the cache. Short-cut results are never cached.
- Hit match requires the entry's valid bit set and equality on op1, op2 and sign. At most one entry can match, because entries are written only on misses.
- DONE: `out_valid`=1; `quo`/`rem`/`out_hit` stable. When `out_ready`=1 → IDLE.
- `flush` (any state): next state IDLE, `out_valid` drops next cycle. Cache contents and pointer are unchanged; a FIX write in the same cycle as `flush` is suppressed.
- `flush` together with an IDLE request: the request is dropped.
- `cache_inv`: clears all valid bits and the pointer at the edge. A lookup in the same cycle is treated as a miss. A FIX write in the same cycle is suppressed.
- Reset: state IDLE, all valid bits 0, pointer 0, `out_valid`=0, `quo`=0, `rem`=0, `out_hit`=0, `in_ready`=1 after the reset edge.
- Reset mid-CALC discards the operation.

## Timing
- Accept edge E0 = edge with `in_valid`&`in_ready`.
- Short-cut: `out_valid` high in the cycle after E0 (latency 1).
- Miss: CALC during cycles E0+1…E0+DATA_W, FIX during cycle E0+DATA_W+1, `out_valid` from E0+DATA_W+2 (34 cycles at DATA_W=32).
- Back-to-back: the earliest next accept is the cycle after the DONE handshake. There is no overlap.
- `out_valid` with `out_ready` low: outputs hold indefinitely.
- Outputs are registered. `in_ready` depends only on state, with no combinational path from `in_valid`.

## Structure
- Shared package `div_pkg`: state enum (IDLE/CALC/FIX/DONE), sign-fix helper functions, overflow/zero detect constants parametrised by DATA_W.
- Sub-module `div_result_cache` (CACHE_DEPTH×{op1, op2, sign, quo, rem, valid}):
  - Parallel match output (hit plus data).
  - Write port with round-robin pointer.
  - Invalidate input.
- Top level holds the FSM, counter, partial remainder/quotient shift registers, abs/negate logic and output registers.

## Test plan
- Unsigned 100/7, `out_ready`=1 → `quo`=14, `rem`=2, `out_hit`=0, `out_valid` at E0+34. Repeat the same request → same result, `out_hit`=1, latency 1.
- Signed −7/2 (0xFFFFFFF9, 2) → `quo`=0xFFFFFFFD, `rem`=0xFFFFFFFF; unsigned on the same operands → `quo`=0x7FFFFFFC, `rem`=1, miss (sign differs).
- 5/0 → `quo`=0xFFFFFFFF, `rem`=5; 0/9 → 0/0; signed 0x80000000/0xFFFFFFFF → `quo`=0x80000000, `rem`=0. All at latency 1, none cached.
- DEPTH=2: miss A, B, C, then A again → A misses (evicted). `cache_inv`, then B → miss.
- `flush` at E0+10 → `out_valid` never rises, `in_ready`=1 at E0+11; the same request afterwards misses (no cache write).
- Hold `out_ready`=0 for 5 cycles in DONE → `quo`/`rem` stable, `in_ready`=0. Assert `rstn`=0 mid-CALC → all outputs at reset values next cycle, cache empty.
